// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register with multi-cycle accumulator carry and per-lane valid.
// Defining EX_MEM_PERF_CNT_EN adds saturating bubble/hold/flush counters.
module ex_mem_stage_reg #(
  parameter int LANES    = 1,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int STALL_W  = 6,
  parameter int STAGE    = 3,
  parameter int MC_CNT_W = 2,
  parameter int PERF_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         ex_valid,
  input  logic [LANES*ADDR_W-1:0]  ex_wd,
  input  logic [LANES-1:0]         ex_wreg,
  input  logic [LANES*DATA_W-1:0]  ex_wdata,
  input  logic [DATA_W-1:0]        ex_hi,
  input  logic [DATA_W-1:0]        ex_lo,
  input  logic                     ex_whilo,
  input  logic [2*DATA_W-1:0]      mc_hilo_i,
  input  logic [MC_CNT_W-1:0]      mc_cnt_i,
  output logic [LANES-1:0]         mem_valid,
  output logic [LANES*ADDR_W-1:0]  mem_wd,
  output logic [LANES-1:0]         mem_wreg,
  output logic [LANES*DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]        mem_hi,
  output logic [DATA_W-1:0]        mem_lo,
  output logic                     mem_whilo,
  output logic [2*DATA_W-1:0]      mc_hilo_o,
  output logic [MC_CNT_W-1:0]      mc_cnt_o,
  output logic                     mc_busy
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]        perf_bubble,
  output logic [PERF_W-1:0]        perf_hold,
  output logic [PERF_W-1:0]        perf_flush
`endif
);
  logic stop, down;
  assign stop = stall[STAGE];
  assign down = stall[STAGE+1];
  assign mc_busy = |mc_cnt_o;
  always_ff @(posedge clk) begin
    if (rst || flush || (stop && !down)) begin
      mem_valid <= '0;
      mem_wd    <= '0;
      mem_wreg  <= '0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
    end else if (!stop) begin
      mem_valid <= ex_valid;
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg & ex_valid;
      mem_wdata <= ex_wdata;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo & ex_valid[0];
    end
  end
  // EX may still be iterating whenever this stage is stopped, so mc state follows it
  always_ff @(posedge clk) begin
    if (rst || flush || !stop) begin
      mc_hilo_o <= '0;
      mc_cnt_o  <= '0;
    end else begin
      mc_hilo_o <= mc_hilo_i;
      mc_cnt_o  <= mc_cnt_i;
    end
  end
`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble <= '0;
      perf_hold   <= '0;
      perf_flush  <= '0;
    end else begin
      if (flush && !(&perf_flush)) perf_flush <= perf_flush + 1'b1;
      if (!flush && stop && !down && !(&perf_bubble)) perf_bubble <= perf_bubble + 1'b1;
      if (!flush && stop && down && !(&perf_hold)) perf_hold <= perf_hold + 1'b1;
    end
  end
`endif
endmodule
